// File: rtl/mips_exec_controller.sv
// Run-control sequencer for the 5-stage MIPS core: owns the global stall,
// sequences RUN/STEP/STOP/CLEAR commands, drains on HALT and counts executed cycles.
module mips_exec_controller #(
  parameter int          CNT_W        = 32,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic [31:0]      i_id_instruction,
  output logic             o_stall,
  output logic             o_running,
  output logic             o_halted,
  output logic             o_step_done,
  output logic [CNT_W-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t           state_r, state_next_s;
  logic [3:0]       drain_cnt_r, drain_cnt_next_s;
  logic             step_done_r, step_done_next_s;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic             cmd_acc_s, halt_seen_s, clear_s;

  // Outputs are pure decodes of registered state, so no input reaches an output.
  assign o_stall       = (state_r == ST_IDLE) || (state_r == ST_HALTED);
  assign o_cmd_ready   = (state_r == ST_IDLE) || (state_r == ST_RUN) || (state_r == ST_HALTED);
  assign o_running     = (state_r == ST_RUN) || (state_r == ST_STEP) || (state_r == ST_DRAIN);
  assign o_halted      = (state_r == ST_HALTED);
  assign o_step_done   = step_done_r;
  assign o_cycle_count = cycle_cnt_r;

  assign cmd_acc_s   = i_cmd_valid && o_cmd_ready;
  assign halt_seen_s = (i_id_instruction == HALT_WORD);

  // Next-state decode; HALT in ID outranks a coincident STOP.
  always_comb begin
    state_next_s     = state_r;
    drain_cnt_next_s = drain_cnt_r;
    step_done_next_s = 1'b0;
    clear_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_acc_s) begin
          case (i_cmd)
            CMD_RUN:   state_next_s = ST_RUN;
            CMD_STEP:  state_next_s = ST_STEP;
            CMD_CLEAR: clear_s      = 1'b1;
            default:   state_next_s = ST_IDLE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_seen_s) begin
          state_next_s     = ST_DRAIN;
          drain_cnt_next_s = DRAIN_LOAD;
        end else if (cmd_acc_s && (i_cmd == CMD_STOP)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_STEP: begin
        if (halt_seen_s) begin
          state_next_s     = ST_DRAIN;
          drain_cnt_next_s = DRAIN_LOAD;
        end else begin
          state_next_s     = ST_IDLE;
          step_done_next_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == 4'd0) begin
          state_next_s = ST_HALTED;
        end else begin
          drain_cnt_next_s = drain_cnt_r - 4'd1;
        end
      end
      ST_HALTED: begin
        if (cmd_acc_s && (i_cmd == CMD_CLEAR)) begin
          state_next_s = ST_IDLE;
          clear_s      = 1'b1;
        end else begin
          state_next_s = ST_HALTED;
        end
      end
      default: begin
        state_next_s     = ST_IDLE;
        drain_cnt_next_s = 4'd0;
      end
    endcase
  end

  // State, drain counter and step-done pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 4'd0;
      step_done_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      drain_cnt_r <= drain_cnt_next_s;
      step_done_r <= step_done_next_s;
    end
  end

  // Saturating executed-cycle counter; CLEAR wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_r <= '0;
    end else if (clear_s) begin
      cycle_cnt_r <= '0;
    end else if (!o_stall && (cycle_cnt_r != {CNT_W{1'b1}})) begin
      cycle_cnt_r <= cycle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

endmodule

// File: tb/tb_mips_exec_controller.sv
// Self-checking bench for mips_exec_controller: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_mips_exec_controller;

  localparam logic [1:0]  C_CLEAR = 2'b00;
  localparam logic [1:0]  C_RUN   = 2'b01;
  localparam logic [1:0]  C_STEP  = 2'b10;
  localparam logic [1:0]  C_STOP  = 2'b11;
  localparam logic [31:0] HALT    = 32'hFFFFFFFF;
  localparam int          DRAIN   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [31:0] instr = 32'h0000_0000;
  logic        cmd_ready, stall, running, halted, step_done;
  logic [31:0] cycle_count;
  logic        cmd_ready4, stall4, running4, halted4, step_done4;
  logic [3:0]  cycle_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_exec_controller u_dut (
    .clk(clk), .rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready),
    .i_id_instruction(instr), .o_stall(stall), .o_running(running), .o_halted(halted),
    .o_step_done(step_done), .o_cycle_count(cycle_count)
  );

  mips_exec_controller #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready4),
    .i_id_instruction(instr), .o_stall(stall4), .o_running(running4), .o_halted(halted4),
    .o_step_done(step_done4), .o_cycle_count(cycle_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({stall, cmd_ready, halted, running, step_done} !== 5'b11000 || cycle_count !== 32'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: stall/ready/halted/running/done=%b cnt=%0d, want 11000 cnt=0",
                 i, {stall, cmd_ready, halted, running, step_done}, cycle_count);
      end
    end
  endtask

  task automatic test_run_stop();
    send(C_RUN);
    for (int e = 1; e <= 7; e++) begin
      checks++;
      if (stall !== 1'b0 || running !== 1'b1) begin
        errors++;
        $display("FAIL run_unstalled before edge %0d: stall=%b running=%b, want 0 1", e, stall, running);
      end
      if (e < 7) tick();
    end
    send(C_STOP);
    checks++;
    if (stall !== 1'b1 || running !== 1'b0 || cmd_ready !== 1'b1 || cycle_count !== 32'd7) begin
      errors++;
      $display("FAIL run_stop: stall=%b running=%b ready=%b cnt=%0d, want 1 0 1 cnt=7",
               stall, running, cmd_ready, cycle_count);
    end
  endtask

  task automatic test_step();
    send(C_CLEAR);
    for (int s = 0; s < 3; s++) begin
      send(C_STEP);
      checks++;
      if (stall !== 1'b0 || cmd_ready !== 1'b0 || step_done !== 1'b0) begin
        errors++;
        $display("FAIL step_window %0d: stall=%b ready=%b done=%b, want 0 0 0", s, stall, cmd_ready, step_done);
      end
      tick();
      checks++;
      if (stall !== 1'b1 || step_done !== 1'b1) begin
        errors++;
        $display("FAIL step_done %0d: stall=%b done=%b, want 1 1", s, stall, step_done);
      end
      tick();
      checks++;
      if (step_done !== 1'b0) begin
        errors++;
        $display("FAIL step_pulse_len %0d: done=%b, want 0", s, step_done);
      end
    end
    checks++;
    if (cycle_count !== 32'd3) begin
      errors++;
      $display("FAIL step_count: cnt=%0d, want 3", cycle_count);
    end
  endtask

  task automatic test_halt_drain();
    send(C_CLEAR);
    send(C_RUN);
    for (int e = 1; e <= 4; e++) tick();
    instr = HALT;
    tick();
    instr = 32'h2002_0001;
    checks++;
    if (running !== 1'b1 || cmd_ready !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL drain_entry: running=%b ready=%b stall=%b, want 1 0 0", running, cmd_ready, stall);
    end
    for (int e = 6; e <= 8; e++) begin
      tick();
      checks++;
      if (halted !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold edge %0d: halted=%b stall=%b, want 0 0", e, halted, stall);
      end
    end
    tick();
    checks++;
    if (halted !== 1'b1 || stall !== 1'b1 || running !== 1'b0 || cycle_count !== 32'd9) begin
      errors++;
      $display("FAIL halted: halted=%b stall=%b running=%b cnt=%0d, want 1 1 0 cnt=9",
               halted, stall, running, cycle_count);
    end
    send(C_RUN);
    checks++;
    if (halted !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL halted_ignores_run: halted=%b stall=%b, want 1 1", halted, stall);
    end
    send(C_CLEAR);
    checks++;
    if (halted !== 1'b0 || stall !== 1'b1 || cmd_ready !== 1'b1 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL halted_clear: halted=%b stall=%b ready=%b cnt=%0d, want 0 1 1 cnt=0",
               halted, stall, cmd_ready, cycle_count);
    end
  endtask

  task automatic test_priority();
    send(C_RUN);
    tick();
    instr = HALT;
    send(C_STOP);
    instr = 32'h0;
    checks++;
    if (running !== 1'b1 || stall !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL halt_over_stop: running=%b stall=%b ready=%b, want 1 0 0", running, stall, cmd_ready);
    end
    for (int i = 0; i < DRAIN; i++) tick();
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_over_stop_halted: halted=%b, want 1", halted);
    end
    send(C_CLEAR);
  endtask

  task automatic test_saturation();
    send(C_CLEAR);
    send(C_RUN);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (cycle_count4 !== 4'hF || cycle_count !== 32'd20) begin
      errors++;
      $display("FAIL saturation: cnt4=%h cnt32=%0d, want f and 20", cycle_count4, cycle_count);
    end
    send(C_STOP);
    send(C_CLEAR);
  endtask

  task automatic test_async_reset();
    send(C_RUN);
    instr = HALT;
    tick();
    instr = 32'h0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({stall, cmd_ready, halted, running, step_done} !== 5'b11000 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: stall/ready/halted/running/done=%b cnt=%0d, want 11000 cnt=0",
               {stall, cmd_ready, halted, running, step_done}, cycle_count);
    end
    #2 rst = 1'b1;
    test_run_stop();
  endtask

  task automatic test_random();
    int     m_mode;   // 0 idle, 1 run, 2 step, 3 drain, 4 halted
    int     m_left;
    bit     m_done;
    longint m_cnt;
    bit     m_stall, m_ready, acc, is_halt;
    tick();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    m_mode = 0; m_left = 0; m_done = 0; m_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd = 2'($urandom_range(0, 3));
      instr = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      m_stall = (m_mode == 0) || (m_mode == 4);
      m_ready = (m_mode == 0) || (m_mode == 1) || (m_mode == 4);
      acc = cmd_valid && m_ready;
      is_halt = (instr == HALT);
      if (!m_stall && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      m_done = 0;
      if (m_mode == 0) begin
        if (acc && cmd == C_RUN) m_mode = 1;
        else if (acc && cmd == C_STEP) m_mode = 2;
        else if (acc && cmd == C_CLEAR) m_cnt = 0;
      end else if (m_mode == 1 || m_mode == 2) begin
        if (is_halt) begin
          m_mode = 3;
          m_left = DRAIN;
        end else if (m_mode == 2) begin
          m_mode = 0;
          m_done = 1;
        end else if (acc && cmd == C_STOP) begin
          m_mode = 0;
        end
      end else if (m_mode == 3) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 4;
      end else if (acc && cmd == C_CLEAR) begin
        m_mode = 0;
        m_cnt = 0;
      end
      tick();
      m_stall = (m_mode == 0) || (m_mode == 4);
      m_ready = (m_mode == 0) || (m_mode == 1) || (m_mode == 4);
      checks++;
      if (stall !== m_stall || cmd_ready !== m_ready || running !== !m_stall ||
          halted !== (m_mode == 4) || step_done !== m_done || cycle_count !== m_cnt[31:0]) begin
        errors++;
        $display("FAIL random cyc=%0d: stall=%b ready=%b run=%b halt=%b done=%b cnt=%0d, want %b %b %b %b %b %0d",
                 i, stall, cmd_ready, running, halted, step_done, cycle_count,
                 m_stall, m_ready, !m_stall, (m_mode == 4), m_done, m_cnt[31:0]);
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #12 rst = 1'b1;
    test_reset();
    test_run_stop();
    test_step();
    test_halt_drain();
    test_priority();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_exec_controller.md
Name: mips_exec_controller

Overview:
- Run-control sequencer for the 5-stage MIPS core; sole driver of the core's global stall input.
- Accepts RUN / STEP / STOP / CLEAR commands from the debug/host side over a valid/ready handshake.
- Detects the HALT word in the decode stage and drains the pipeline before freezing it.
- Keeps a saturating count of executed (unstalled) cycles for the host.

Parameters:
- CNT_W, 32, width of the executed-cycle counter.
- DRAIN_CYCLES, 4, unstalled cycles granted after HALT is seen in ID (EX, MEM, WB, plus one margin); legal range 1..15.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding treated as HALT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
- i_cmd_valid  input  1  command present.
- i_cmd  input  2  command code: 00 CLEAR, 01 RUN, 10 STEP, 11 STOP.
- o_cmd_ready  output  1  controller can accept a command this cycle.
- i_id_instruction  input  32  instruction currently held in the IF/ID latch.
- o_stall  output  1  drives the core stall; 1 freezes PC and all pipeline latches.
- o_running  output  1  high in RUN, STEP and DRAIN.
- o_halted  output  1  high in HALTED.
- o_step_done  output  1  one-cycle pulse when a STEP completes.
- o_cycle_count  output  CNT_W  number of cycles with o_stall=0.

Behaviour:
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- Reset (rst=0, asynchronous):
  - state=IDLE, drain counter=0, o_cycle_count=0.
  - o_stall=1, o_cmd_ready=1, o_running=0, o_halted=0, o_step_done=0.
- Handshake:
  - A command is accepted on a rising edge where i_cmd_valid=1 and o_cmd_ready=1.
  - An accepted command that is illegal in the current state is consumed and ignored.
  - o_cmd_ready=1 in IDLE, RUN and HALTED; 0 in STEP and DRAIN.
- State IDLE (o_stall=1):
  - RUN -> RUN.
  - STEP -> STEP.
  - CLEAR -> stays IDLE, o_cycle_count=0.
  - STOP -> ignored.
- State RUN (o_stall=0):
  - STOP accepted -> IDLE; o_stall=1 from the next cycle.
  - i_id_instruction==HALT_WORD -> DRAIN, drain counter loaded with DRAIN_CYCLES-1.
  - If STOP and HALT coincide on the same edge, HALT wins (-> DRAIN).
  - RUN, STEP and CLEAR are ignored.
- State STEP (o_stall=0 for exactly one cycle):
  - Normally -> IDLE with o_step_done=1 for one cycle (the first cycle back in IDLE).
  - If i_id_instruction==HALT_WORD during the step cycle -> DRAIN; no o_step_done pulse.
- State DRAIN (o_stall=0):
  - Drain counter decrements each cycle.
  - Counter at 0 -> HALTED; total of exactly DRAIN_CYCLES unstalled cycles spent in DRAIN.
  - HALT_WORD seen again during DRAIN is ignored.
- State HALTED (o_stall=1, o_halted=1):
  - Only CLEAR is honoured -> IDLE, o_cycle_count=0.
  - All other commands are ignored.
- Cycle counter:
  - +1 on every rising edge where o_stall=0.
  - Saturates at all-ones; no wrap.
  - CLEAR reset takes priority over increment.
- Reset mid-operation (any state, any drain count): immediate return to reset values; the pending command is lost.
- Mapping of state to outputs:
  - o_running = state in {RUN, STEP, DRAIN}.
  - o_stall = state in {IDLE, HALTED}.

Test Plan:
- Reset then idle: release rst, hold i_cmd_valid=0 for 10 cycles -> o_stall=1, o_cmd_ready=1, o_cycle_count=0, o_halted=0 throughout.
- Run then stop: RUN accepted at edge 0, STOP accepted at edge 7 -> o_stall=0 for cycles 1..7, o_stall=1 from cycle 8, o_cycle_count=7, state IDLE.
- Step x3: three STEP commands, each issued after the previous o_step_done -> three single-cycle o_stall=0 windows, three o_step_done pulses, o_cycle_count=3.
- HALT drain: RUN accepted, i_id_instruction=32'hFFFFFFFF at the 5th unstalled edge -> 4 further unstalled cycles, then o_halted=1, o_stall=1, o_cycle_count=9; a following RUN is ignored; CLEAR -> IDLE, o_cycle_count=0.
- Priority and saturation:
  - STOP and HALT_WORD on the same edge -> DRAIN taken.
  - CNT_W=4, run 20 cycles -> o_cycle_count holds 4'hF.
- Async reset in DRAIN: drop rst while 2 drain cycles remain -> outputs reach reset values before the next clock edge; a subsequent RUN behaves as in the Run-then-stop scenario.
